binary_to_bcd_encoder: RTL
==========================

Name: binary_to_bcd_encoder

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Produces packed BCD digits that feed the team's BCD-to-seven-segment decoders, one decoder per digit nibble.
- Uses a Start/Busy/Done handshake so a counter or controller can request conversions.

Parameters:
- WIDTH, 8, bit width of the binary input; must be >= 1.
- DIGITS, 3, number of BCD output digits; BCD is 4*DIGITS bits wide.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  conversion request; sampled only in IDLE.
- Binary  input  WIDTH  unsigned value to convert; captured on the accepting edge.
- BCD  output  4*DIGITS  result; digit 0 (units) in bits [3:0], digit k in bits [4k+3:4k].
- Busy  output  1  high while a conversion is in progress.
- Done  output  1  one-cycle pulse when BCD and Overflow have been updated.
- Overflow  output  1  high when the last result did not fit in DIGITS digits.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- Reset values: state = IDLE, BCD = 0, Busy = 0, Done = 0, Overflow = 0, internal shift and scratch registers = 0, bit counter = 0.
- Internal registers:
  - bin_sr: WIDTH-bit binary shift register.
  - bcd_sr: 4*DIGITS-bit BCD scratch register.
  - ovf_acc: overflow accumulator.
  - cnt: bit counter, ceil(log2(WIDTH+1)) bits.
- States: IDLE and SHIFT.
- IDLE, Start = 1 at edge T:
  - bin_sr <= Binary; bcd_sr <= 0; ovf_acc <= 0; cnt <= WIDTH.
  - Busy <= 1; go to SHIFT.
- IDLE, Start = 0: hold all state. Done <= 0.
- SHIFT, each edge:
  - Correct every nibble of bcd_sr: if nibble >= 5, add 3. Use 4-bit arithmetic; the corrected value is at most 12, so no carry out.
  - Shift {bcd_sr, bin_sr} left by one from the corrected value. The bit leaving the top of bcd_sr is ORed into ovf_acc.
  - cnt <= cnt - 1.
- SHIFT, last step (edge where cnt == 1):
  - BCD <= final bcd_sr; Overflow <= final ovf_acc (including this step's shifted-out bit).
  - Done <= 1 for exactly one cycle; Busy <= 0; go to IDLE.
- Latency: Start accepted at edge T gives Done high and the new BCD valid in the cycle after edge T+WIDTH. Busy is high from edge T to edge T+WIDTH.
- BCD and Overflow change only on the completion edge. They hold the previous result throughout a conversion.
- Start while Busy = 1 is ignored (not queued), and Binary changes during SHIFT have no effect.
- Start high in the Done cycle: the state is IDLE, so it is accepted. Back-to-back conversions therefore run every WIDTH+1 cycles.
- Start held high continuously: a new conversion starts on each return to IDLE.
- Overflow: on overflow, BCD holds the low DIGITS digits of the true decimal value.
- Reset asserted mid-conversion: immediate abort to reset values. No Done pulse; the previous BCD is cleared to 0.
- Every output digit is always in the range 0-9.

Test Plan:
- Reset, then Start with Binary = 0 -> Done pulse 8 cycles after acceptance, BCD = 12'h000, Overflow = 0.
- Binary = 255 (8'hFF) -> BCD = 12'h255 exactly WIDTH cycles after acceptance; Busy high for 8 cycles; Done high for exactly 1 cycle.
- Sweep Binary over 0..255 with Start pulsed on each Done -> every BCD matches the decimal value; each conversion takes 9 cycles including the Done cycle; Overflow always 0.
- Start with 8'd137, then Start pulsed with 8'd42 at cycle 3 of Busy -> result BCD = 12'h137; the second request is ignored; no extra Done pulse.
- Start with 8'd200; assert Reset at cycle 4 of Busy -> BCD = 0, Busy = 0, Done stays 0; next Start with 8'd7 gives BCD = 12'h007.
- DIGITS = 2: Binary = 8'd100 -> BCD = 8'h00, Overflow = 1. Binary = 8'd99 -> BCD = 8'h99, Overflow = 0.

Source files
------------

// File: rtl/binary_to_bcd_encoder.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Latency: Start accepted at edge T -> Done pulse and new BCD after edge T+WIDTH.
// Backpressure: none; Start is ignored while Busy and is never queued.
module binary_to_bcd_encoder #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Binary,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] bin_sr;
  logic [BW-1:0]    bcd_sr;
  logic             ovf_acc;
  logic [CW-1:0]    cnt;

  logic [BW-1:0]    corr;
  logic [BW-1:0]    bcd_next;
  logic             carry_out;

  // Add 3 to every nibble that is 5 or more so the following shift carries correctly into the next digit.
  always_comb begin
    corr = bcd_sr;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_sr[4*k +: 4] >= 4'd5) begin
        corr[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top digit is lost from BCD but remembered as an overflow.
  assign bcd_next  = {corr[BW-2:0], bin_sr[WIDTH-1]};
  assign carry_out = corr[BW-1];

  // Control FSM plus datapath registers; all outputs are registered.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      ovf_acc  <= 1'b0;
      cnt      <= '0;
      BCD      <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            bin_sr  <= Binary;
            bcd_sr  <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CW'(WIDTH);
            Busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bin_sr  <= bin_sr << 1;
          bcd_sr  <= bcd_next;
          ovf_acc <= ovf_acc | carry_out;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            BCD      <= bcd_next;
            Overflow <= ovf_acc | carry_out;
            Done     <= 1'b1;
            Busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
